// File: rtl/or1200_keystream_xor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_keystream_xor_pkg
//  Purpose  : Shared constants and helpers for the OFB keystream XOR block
//             (LSU access size codes, pad geometry, size decode).
//  Revision : 1.0  initial release
// ============================================================================
package or1200_keystream_xor_pkg;

    // LSU access size codes as presented on size_i
    localparam logic [1:0] OR1200_KS_SIZE_B = 2'b00;
    localparam logic [1:0] OR1200_KS_SIZE_H = 2'b01;
    localparam logic [1:0] OR1200_KS_SIZE_W = 2'b10;

    // Pad geometry: one AES block of keystream
    localparam int PAD_BYTES  = 16;
    // LSU data path: at most one 32-bit word per access
    localparam int DATA_BYTES = 4;

    // Number of bytes an access consumes; the reserved code behaves as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            OR1200_KS_SIZE_B: size_bytes = 3'd1;
            OR1200_KS_SIZE_H: size_bytes = 3'd2;
            default:          size_bytes = 3'd4;
        endcase
    endfunction

endpackage : or1200_keystream_xor_pkg
`default_nettype wire

// File: rtl/or1200_keystream_xor_byte_select.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_ks_byte_select
//  Purpose  : Picks the next unused pad bytes out of the two-slot pad window
//             and aligns them to the LSU byte lanes. Lanes beyond the access
//             size return zero so the XOR leaves those data bytes untouched.
//  Revision : 1.0  initial release
// ============================================================================
module or1200_ks_byte_select
    import or1200_keystream_xor_pkg::*;
(
    input  logic [2*PAD_BYTES*8-1:0] window,   // {nxt_pad, cur_pad}, byte 0 = cur_pad[7:0]
    input  logic [4:0]               ptr,      // first unused byte of the window
    input  logic [2:0]               nbytes,   // 1, 2 or 4
    output logic [DATA_BYTES*8-1:0]  pad_word
);

    logic [4:0] byte_idx;

    // Lane k takes window byte ptr+k when it lies inside the access, else zero
    always_comb begin
        pad_word = '0;
        byte_idx = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            // ptr never exceeds 15 so ptr+3 stays within the 32-byte window
            byte_idx = ptr + 5'(k);
            if (3'(k) < nbytes) begin
                pad_word[8*k +: 8] = window[{byte_idx, 3'b000} +: 8];
            end
        end
    end

endmodule : or1200_ks_byte_select
`default_nettype wire

// File: rtl/or1200_keystream_xor.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_keystream_xor
//  Purpose  : Consumer end of the OFB pad interface. Holds the current and a
//             prefetched 128-bit pad, XORs the next unused pad bytes onto LSU
//             data, requests the next OFB block and stalls the LSU when the
//             buffered keystream runs short.
//  Revision : 1.0  initial release
// ============================================================================
module or1200_keystream_xor
    import or1200_keystream_xor_pkg::*;
#(
    parameter int PAD_W  = 128,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAD_W-1:0]  pad_i,
    input  logic              pad_valid_i,
    output logic              pad_req_o,
    input  logic              flush_i,
    input  logic              req_i,
    input  logic [1:0]        size_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              stall_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic [7:0]        consumed_o
);

    // ------------------------------------------------------------------
    // State: two pad slots, byte pointer into the current slot, and the
    // request bookkeeping. The (cur_valid, nxt_valid, req_pending) triple
    // is the whole control state; there is no separate FSM register.
    // ------------------------------------------------------------------
    logic [PAD_W-1:0]  cur_pad;
    logic [PAD_W-1:0]  nxt_pad;
    logic              cur_valid;
    logic              nxt_valid;
    logic [3:0]        ptr;
    logic              req_pending;
    logic              drop_next;
    logic              ack;
    logic [DATA_W-1:0] data_q;
    logic              pad_req;

    // Next-state values
    logic [PAD_W-1:0]  cur_pad_n;
    logic [PAD_W-1:0]  nxt_pad_n;
    logic              cur_valid_n;
    logic              nxt_valid_n;
    logic [3:0]        ptr_n;
    logic              req_pending_n;
    logic              drop_next_n;
    logic              pad_req_n;

    // Access decode
    logic [2:0]        nbytes;
    logic [5:0]        avail;
    logic              accept;
    logic [4:0]        ptr_sum;
    logic [DATA_W-1:0] pad_word;

    // Bytes available across both slots and whether the access fits
    always_comb begin
        nbytes  = size_bytes(size_i);
        avail   = (cur_valid ? (6'd16 - {2'b00, ptr}) : 6'd0)
                + (nxt_valid ? 6'd16 : 6'd0);
        // flush and reset both win over a same-cycle access
        accept  = req_i && !flush_i && !rst && (avail >= {3'b000, nbytes});
        ptr_sum = {1'b0, ptr} + {2'b00, nbytes};
    end

    assign stall_o = req_i && !accept;

    // Align the pad bytes for this access to the LSU lanes
    or1200_ks_byte_select u_byte_select (
        .window   ({nxt_pad, cur_pad}),
        .ptr      ({1'b0, ptr}),
        .nbytes   (nbytes),
        .pad_word (pad_word)
    );

    // Slot, pointer and request bookkeeping for the coming cycle
    always_comb begin
        cur_pad_n     = cur_pad;
        nxt_pad_n     = nxt_pad;
        cur_valid_n   = cur_valid;
        nxt_valid_n   = nxt_valid;
        ptr_n         = ptr;
        req_pending_n = req_pending;
        drop_next_n   = drop_next;
        pad_req_n     = 1'b0;

        if (flush_i) begin
            // New seed: everything buffered belongs to the old keystream.
            // A block still in flight must be thrown away when it lands,
            // unless it lands right now, in which case it is dropped here.
            cur_valid_n   = 1'b0;
            nxt_valid_n   = 1'b0;
            ptr_n         = 4'd0;
            req_pending_n = 1'b0;
            drop_next_n   = (req_pending || drop_next) && !pad_valid_i;
        end else begin
            // Consumption first, so an arriving pad sees the freed slot
            if (accept) begin
                if (ptr_sum[4]) begin
                    cur_pad_n   = nxt_pad;
                    cur_valid_n = nxt_valid;
                    nxt_valid_n = 1'b0;
                end
                // Wraps to 0 when exactly the last byte of cur was used
                ptr_n = ptr_sum[3:0];
            end

            // Pad arrival fills the first empty slot, cur before nxt
            if (pad_valid_i) begin
                req_pending_n = 1'b0;
                if (drop_next) begin
                    drop_next_n = 1'b0;
                end else if (!cur_valid_n) begin
                    cur_pad_n   = pad_i;
                    cur_valid_n = 1'b1;
                end else if (!nxt_valid_n) begin
                    nxt_pad_n   = pad_i;
                    nxt_valid_n = 1'b1;
                end
                // both slots full: the pad is lost (upstream protocol error)
            end

            // Prefetch once the spare slot is empty and nothing is in flight.
            // The very first pad after a seed is produced unasked.
            if (cur_valid_n && !nxt_valid_n && !req_pending_n) begin
                pad_req_n     = 1'b1;
                req_pending_n = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_pad     <= '0;
            nxt_pad     <= '0;
            cur_valid   <= 1'b0;
            nxt_valid   <= 1'b0;
            ptr         <= 4'd0;
            req_pending <= 1'b0;
            drop_next   <= 1'b0;
            pad_req     <= 1'b0;
            ack         <= 1'b0;
            data_q      <= '0;
        end else begin
            cur_pad     <= cur_pad_n;
            nxt_pad     <= nxt_pad_n;
            cur_valid   <= cur_valid_n;
            nxt_valid   <= nxt_valid_n;
            ptr         <= ptr_n;
            req_pending <= req_pending_n;
            drop_next   <= drop_next_n;
            pad_req     <= pad_req_n;
            ack         <= accept;
            if (accept) begin
                data_q <= data_i ^ pad_word;
            end
        end
    end

    assign pad_req_o  = pad_req;
    assign ack_o      = ack;
    assign data_o     = data_q;
    assign consumed_o = cur_valid ? {1'b0, ptr, 3'b000} : 8'd0;

endmodule : or1200_keystream_xor
`default_nettype wire

// File: tb/tb_or1200_keystream_xor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_or1200_keystream_xor
//  Purpose  : Directed self-checking bench for or1200_keystream_xor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_or1200_keystream_xor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] pad_i = '0;
    logic         pad_valid_i = 1'b0;
    logic         pad_req_o;
    logic         flush_i = 1'b0;
    logic         req_i = 1'b0;
    logic [1:0]   size_i = 2'b00;
    logic [31:0]  data_i = '0;
    logic         stall_o;
    logic         ack_o;
    logic [31:0]  data_o;
    logic [7:0]   consumed_o;

    int total_cnt  = 0;
    int pass_cnt   = 0;
    int preq_cnt;

    or1200_keystream_xor dut (
        .clk         (clk),
        .rst         (rst),
        .pad_i       (pad_i),
        .pad_valid_i (pad_valid_i),
        .pad_req_o   (pad_req_o),
        .flush_i     (flush_i),
        .req_i       (req_i),
        .size_i      (size_i),
        .data_i      (data_i),
        .stall_o     (stall_o),
        .ack_o       (ack_o),
        .data_o      (data_o),
        .consumed_o  (consumed_o)
    );

    always #5 clk = ~clk;

    // Count pad_req_o pulses since the last reset
    always @(posedge clk) begin
        if (rst)            preq_cnt <= 0;
        else if (pad_req_o) preq_cnt <= preq_cnt + 1;
    end

    // A pad must never arrive while the prefetch slot is already occupied
    always @(posedge clk) begin
        if (!rst && pad_valid_i && !flush_i && !dut.drop_next && dut.nxt_valid) begin
            total_cnt = total_cnt + 1;
            $display("FAIL pad_overrun got=1 exp=0");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             pass_cnt = pass_cnt + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pad strobe; pad bytes are base, base+1, ... base+15
    task automatic send_pad(input logic [7:0] base);
        for (int b = 0; b < 16; b++) pad_i[8*b +: 8] = base + 8'(b);
        pad_valid_i = 1'b1;
        tick();
        pad_valid_i = 1'b0;
    endtask

    // Issue one LSU access, wait (bounded) for acceptance, check the result
    task automatic access(input logic [1:0] sz, input logic [31:0] d, input string tag,
                          input logic [31:0] exp_data, input logic [7:0] exp_cons);
        logic done;
        int   n;
        req_i  = 1'b1;
        size_i = sz;
        data_i = d;
        done   = 1'b0;
        n      = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            if (!stall_o) done = 1'b1;
            tick();
            n++;
        end
        req_i = 1'b0;
        check({tag, "_accepted"}, 32'(done), 32'd1);
        check({tag, "_ack"},      32'(ack_o), 32'd1);
        check({tag, "_data"},     data_o, exp_data);
        check({tag, "_consumed"}, 32'(consumed_o), 32'(exp_cons));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ack",      32'(ack_o), 32'd0);
        check("rst_data",     data_o, 32'd0);
        check("rst_consumed", 32'(consumed_o), 32'd0);
        check("rst_padreq",   32'(pad_req_o), 32'd0);
        @(negedge clk);
        check("rst_stall_idle", 32'(stall_o), 32'd0);
        tick();
        req_i = 1'b1;
        @(negedge clk);
        check("rst_stall_nopad", 32'(stall_o), 32'd1);
        tick();
        req_i = 1'b0;

        // ---------------- 1: first pad, word access ----------------
        send_pad(8'h00);
        check("t1_padreq_hi", 32'(pad_req_o), 32'd1);
        tick();
        check("t1_padreq_lo", 32'(pad_req_o), 32'd0);
        access(2'b10, 32'hFFFF_FFFF, "t1", 32'hFCFD_FEFF, 8'd32);
        tick();
        check("t1_ack_drop", 32'(ack_o), 32'd0);
        check("t1_preq_cnt", 32'(preq_cnt), 32'd1);

        // ---------------- 2: straddle into nxt ----------------
        access(2'b10, 32'h0, "t2a", 32'h0706_0504, 8'd64);
        access(2'b10, 32'h0, "t2b", 32'h0B0A_0908, 8'd96);
        access(2'b01, 32'h0, "t2c", 32'h0000_0D0C, 8'd112);
        send_pad(8'h10);
        check("t2_no_padreq", 32'(pad_req_o), 32'd0);
        access(2'b10, 32'h0, "t2d", 32'h1110_0F0E, 8'd16);
        check("t2_padreq", 32'(pad_req_o), 32'd1);

        // ---------------- 3: stall at ptr 15, refill arrives ----------------
        access(2'b10, 32'h0, "t3a", 32'h1514_1312, 8'd48);
        access(2'b10, 32'h0, "t3b", 32'h1918_1716, 8'd80);
        access(2'b10, 32'h0, "t3c", 32'h1D1C_1B1A, 8'd112);
        access(2'b00, 32'h0, "t3d", 32'h0000_001E, 8'd120);
        req_i  = 1'b1;
        size_i = 2'b01;
        data_i = 32'h0;
        @(negedge clk);
        check("t3_stall0", 32'(stall_o), 32'd1);
        tick();
        @(negedge clk);
        check("t3_stall1", 32'(stall_o), 32'd1);
        check("t3_noack",  32'(ack_o), 32'd0);
        tick();
        send_pad(8'h20);
        access(2'b01, 32'h0, "t3e", 32'h0000_201F, 8'd8);
        check("t3_padreq", 32'(pad_req_o), 32'd1);

        // ---------------- 4: flush with a request outstanding ----------------
        flush_i = 1'b1;
        req_i   = 1'b1;
        size_i  = 2'b10;
        data_i  = 32'h0;
        @(negedge clk);
        check("t4_flush_stall", 32'(stall_o), 32'd1);
        tick();
        flush_i = 1'b0;
        req_i   = 1'b0;
        check("t4_flush_noack", 32'(ack_o), 32'd0);
        check("t4_consumed",    32'(consumed_o), 32'd0);
        send_pad(8'h30);
        check("t4_stale_noreq", 32'(pad_req_o), 32'd0);
        req_i = 1'b1;
        @(negedge clk);
        check("t4_stale_dropped", 32'(stall_o), 32'd1);
        tick();
        req_i = 1'b0;
        send_pad(8'h40);
        check("t4_seed_padreq", 32'(pad_req_o), 32'd1);
        access(2'b10, 32'hFFFF_FFFF, "t4", 32'hBCBD_BEBF, 8'd32);
        check("t4_preq_cnt", 32'(preq_cnt), 32'd4);

        // ---------------- 5: drain one pad with byte accesses ----------------
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        send_pad(8'h50);
        for (int i = 0; i < 16; i++) begin
            access(2'b00, 32'h0, $sformatf("t5_%0d", i), {24'h0, 8'h50 + 8'(i)},
                   (i < 15) ? 8'(8 * (i + 1)) : 8'd0);
        end
        check("t5_cur_valid", 32'(dut.cur_valid), 32'd0);
        req_i  = 1'b1;
        size_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5_stall_%0d", i), 32'(stall_o), 32'd1);
            tick();
        end
        req_i = 1'b0;
        check("t5_preq_cnt", 32'(preq_cnt), 32'd1);

        // ---------------- 6: reset mid-access ----------------
        send_pad(8'h60);
        req_i       = 1'b1;
        size_i      = 2'b10;
        data_i      = 32'hFFFF_FFFF;
        rst         = 1'b1;
        pad_i       = {16{8'hA5}};
        pad_valid_i = 1'b1;
        @(negedge clk);
        check("t6_stall_in_rst", 32'(stall_o), 32'd1);
        tick();
        rst         = 1'b0;
        pad_valid_i = 1'b0;
        check("t6_ack",      32'(ack_o), 32'd0);
        check("t6_data",     data_o, 32'd0);
        check("t6_consumed", 32'(consumed_o), 32'd0);
        check("t6_padreq",   32'(pad_req_o), 32'd0);
        @(negedge clk);
        check("t6_stall", 32'(stall_o), 32'd1);
        tick();
        req_i = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_or1200_keystream_xor
`default_nettype wire
